// File: rtl/mls_pkg.sv
// Shared types and constants for the truth-table evaluator.
package mls_pkg;

   localparam int unsigned NDefault = 5;

   typedef enum logic [1:0] {
      StIdle,
      StSweep,
      StDone
   } state_e;

endpackage

// File: rtl/mls_lut.sv
// Truth-table register with two independent combinational read ports.
module mls_lut
   import mls_pkg::*;
#(
   parameter int unsigned N    = NDefault,
   parameter int unsigned TT_W = 1 << N
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            we,
   input  logic [TT_W-1:0] wdata,
   input  logic [N-1:0]    idx_a,
   output logic            bit_a,
   input  logic [N-1:0]    idx_b,
   output logic            bit_b
);

   logic [TT_W-1:0] tt_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         tt_q <= '0;
      end else if (we) begin
         tt_q <= wdata;
      end
   end

   assign bit_a = tt_q[idx_a];
   assign bit_b = tt_q[idx_b];

endmodule

// File: rtl/mls_lut_eval.sv
// Boolean function evaluator: direct lookup plus an exhaustive minterm sweep
// reporting the number of true minterms and the lowest true index.
module mls_lut_eval
   import mls_pkg::*;
#(
   parameter int unsigned  N    = NDefault,
   localparam int unsigned TT_W = 1 << N
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            load,
   input  logic [TT_W-1:0] tt_in,
   input  logic [N-1:0]    in_vec,
   output logic            f,
   input  logic            start,
   output logic            busy,
   output logic            done,
   output logic [N:0]      count,
   output logic [N-1:0]    first_idx,
   output logic            found
);

   state_e       state_q, state_d;
   logic [N-1:0] idx_q, idx_d;
   logic [N:0]   count_q, count_d;
   logic [N-1:0] first_q, first_d;
   logic         found_q, found_d;
   logic         f_q;
   logic         load_en;
   logic         f_bit;
   logic         sweep_bit;

   // The table is frozen while the sweep walks it.
   assign load_en = load & (state_q != StSweep);

   mls_lut #(
      .N    (N),
      .TT_W (TT_W)
   ) u_lut (
      .clk   (clk),
      .rst   (rst),
      .we    (load_en),
      .wdata (tt_in),
      .idx_a (in_vec),
      .bit_a (f_bit),
      .idx_b (idx_q),
      .bit_b (sweep_bit)
   );

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      count_d = count_q;
      first_d = first_q;
      found_d = found_q;
      unique case (state_q)
         StIdle: begin
            if (start) begin
               state_d = StSweep;
               idx_d   = '0;
               count_d = '0;
               first_d = '0;
               found_d = 1'b0;
            end
         end
         StSweep: begin
            if (sweep_bit) begin
               count_d = count_q + 1'b1;
               if (!found_q) begin
                  found_d = 1'b1;
                  first_d = idx_q;
               end
            end
            // Terminal compare instead of wrapping the index.
            if (&idx_q) begin
               state_d = StDone;
            end else begin
               idx_d = idx_q + 1'b1;
            end
         end
         StDone: begin
            state_d = StIdle;
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= StIdle;
         idx_q   <= '0;
         count_q <= '0;
         first_q <= '0;
         found_q <= 1'b0;
         f_q     <= 1'b0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         count_q <= count_d;
         first_q <= first_d;
         found_q <= found_d;
         f_q     <= f_bit;
      end
   end

   assign f         = f_q;
   assign busy      = (state_q == StSweep);
   assign done      = (state_q == StDone);
   assign count     = count_q;
   assign first_idx = first_q;
   assign found     = found_q;

endmodule

// File: doc/mls_lut_eval.md
MLS_LUT_EVAL -- requirements
Module: mls_lut_eval

Interface
REQ-001 Parameter N, default 5: number of boolean inputs to the evaluated function, legal range 2..8.
REQ-002 Parameter TT_W, default 2**N: truth-table width, derived and not user-overridden.
REQ-003 clk  in  1  single clock, all state on rising edge.
REQ-004 rst  in  1  synchronous, active-high reset.
REQ-005 load  in  1  write tt_in into truth-table register.
REQ-006 tt_in  in  TT_W  truth table; bit k = function value for input vector k.
REQ-007 in_vec  in  N  input vector for direct evaluation.
REQ-008 f  out  1  registered function value tt[in_vec].
REQ-009 start  in  1  request exhaustive minterm sweep.
REQ-010 busy  out  1  sweep in progress.
REQ-011 done  out  1  single-cycle pulse at sweep completion.
REQ-012 count  out  N+1  number of true minterms from last sweep.
REQ-013 first_idx  out  N  lowest true minterm index from last sweep.
REQ-014 found  out  1  at least one true minterm in last sweep.

Function
REQ-015 Table register SHALL capture tt_in on any rising edge with load=1 while not busy; load while busy SHALL be ignored.
REQ-016 f SHALL equal tt[in_vec] sampled at the previous edge (1-cycle latency), evaluated against the table value before that edge's load.
REQ-017 FSM states SHALL be IDLE, SWEEP, DONE.
REQ-018 IDLE -> SWEEP on start=1; simultaneous load=1 and start=1 SHALL load first, so the sweep uses the new table.
REQ-019 On entering SWEEP, count, first_idx and found SHALL clear to 0, and index SHALL be 0.
REQ-020 SWEEP SHALL examine one index per cycle, indices 0..TT_W-1 ascending; each true bit increments count.
REQ-021 first_idx/found SHALL be set at the first true index only; later true bits do not change them.
REQ-022 SWEEP -> DONE after index TT_W-1 is examined (no wrap of index; counter width N+1 or terminal compare).
REQ-023 Timing: start at edge t -> busy=1 for cycles t+1..t+TT_W; done=1 for exactly cycle t+TT_W+1 (DONE state); IDLE afterwards.
REQ-024 busy SHALL be 0 in IDLE and DONE; done SHALL be 0 outside DONE.
REQ-025 start during SWEEP or DONE SHALL be ignored (not queued).
REQ-026 count, first_idx, found SHALL hold their values from DONE until the next sweep begins.
REQ-027 count SHALL reach TT_W for an all-ones table without overflow.
REQ-028 Direct evaluation (f) SHALL keep operating during a sweep.

Reset
REQ-029 rst=1 SHALL force: state IDLE, table 0, f 0, busy 0, done 0, count 0, first_idx 0, found 0, index 0.
REQ-030 rst during SWEEP SHALL abort the sweep with no done pulse; rst SHALL dominate simultaneous load/start.

Structure
REQ-031 Package mls_pkg SHALL hold the FSM state type (IDLE/SWEEP/DONE) and the default N constant.
REQ-032 One sub-module mls_lut SHALL hold the truth-table register and the indexed read mux (two read ports: in_vec and sweep index).
REQ-033 The FSM, counters and result registers SHALL reside in mls_lut_eval.

Verification (N=5)
REQ-034 load tt=32'h0000_0004, in_vec=2 -> f=1 one cycle later; in_vec=3 -> f=0.
REQ-035 tt=32'h0000_0000, start -> done at cycle t+33, count=0, found=0, first_idx=0.
REQ-036 tt=32'hFFFF_FFFF, start -> busy for 32 cycles, count=32, first_idx=0, found=1.
REQ-037 tt=32'h8000_0000, start -> count=1, first_idx=31; start pulsed mid-sweep has no effect.
REQ-038 Same-cycle load tt=32'h0000_0300 and start -> count=2, first_idx=8; load during busy is ignored.
REQ-039 rst at sweep cycle 10 -> no done pulse, all outputs 0 next cycle, table 0.
